// File: rtl/seq_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Summary  : ALU with single-cycle logic/arithmetic/shift ops and iterative
//            bit-serial multiply (shift-add) and divide (restoring).
// Revision : 1.0
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       AluOp,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Equal
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [4:0] c_OP_SLL  = 5'd0;
    localparam logic [4:0] c_OP_SRA  = 5'd1;
    localparam logic [4:0] c_OP_SRL  = 5'd2;
    localparam logic [4:0] c_OP_ADD  = 5'd5;
    localparam logic [4:0] c_OP_SUB  = 5'd6;
    localparam logic [4:0] c_OP_AND  = 5'd7;
    localparam logic [4:0] c_OP_OR   = 5'd8;
    localparam logic [4:0] c_OP_XOR  = 5'd9;
    localparam logic [4:0] c_OP_NOR  = 5'd10;
    localparam logic [4:0] c_OP_SLT  = 5'd11;
    localparam logic [4:0] c_OP_SLTU = 5'd12;

    localparam logic [SHW-1:0]   c_LAST    = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Control and output registers
    logic [0:0]       r_state;
    logic [SHW-1:0]   r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_equal;

    // Iteration datapath: r_hi is accumulator/remainder, r_lo is
    // multiplier/quotient, r_b is multiplicand/divisor magnitude.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_x;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic             r_ovf;
    logic             r_eq;

    logic             w_accept;
    logic             w_is_mc;
    logic             w_signed_op;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_x_neg;
    logic             w_y_neg;
    logic [WIDTH-1:0] w_x_mag;
    logic [WIDTH-1:0] w_y_mag;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0] w_fin_lo;
    logic [WIDTH-1:0] w_fin_hi;

    assign in_ready  = (r_state == c_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign ResultHi  = r_result_hi;
    assign Equal     = r_equal;

    assign w_accept    = in_valid && in_ready;
    assign w_is_mc     = (AluOp[4:2] == 3'b100);
    assign w_signed_op = !AluOp[0];
    assign w_shamt     = Y[SHW-1:0];

    assign w_x_neg = w_signed_op && X[WIDTH-1];
    assign w_y_neg = w_signed_op && Y[WIDTH-1];
    assign w_x_mag = w_x_neg ? -X : X;
    assign w_y_mag = w_y_neg ? -Y : Y;

    always_comb begin
        w_alu_res = '0;
        case (AluOp)
            c_OP_SLL:  w_alu_res = X << w_shamt;
            c_OP_SRA:  w_alu_res = $signed(X) >>> w_shamt;
            c_OP_SRL:  w_alu_res = X >> w_shamt;
            c_OP_ADD:  w_alu_res = X + Y;
            c_OP_SUB:  w_alu_res = X - Y;
            c_OP_AND:  w_alu_res = X & Y;
            c_OP_OR:   w_alu_res = X | Y;
            c_OP_XOR:  w_alu_res = X ^ Y;
            c_OP_NOR:  w_alu_res = ~(X | Y);
            c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
            c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (X < Y)};
            default:   w_alu_res = '0;
        endcase
    end

    // One multiply step: conditionally add, then shift {carry, hi, lo} right.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // One restoring divide step: the remainder is always below the divisor,
    // so a (WIDTH+1)-bit difference resolves the compare by its top bit.
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_ge     = !w_diff[WIDTH];
    assign w_div_hi = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

    assign w_next_hi = r_is_div ? w_div_hi : w_mul_sum[WIDTH:1];
    assign w_next_lo = r_is_div ? {r_lo[WIDTH-2:0], w_ge}
                                : {w_mul_sum[0], r_lo[WIDTH-1:1]};

    assign w_prod   = {w_next_hi, w_next_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_fin_lo = '0;
        w_fin_hi = '0;
        if (r_is_div) begin
            if (r_div0) begin
                w_fin_lo = '1;
                w_fin_hi = r_x;
            end else if (r_ovf) begin
                w_fin_lo = r_x;
                w_fin_hi = '0;
            end else begin
                w_fin_lo = r_neg_q ? -w_next_lo : w_next_lo;
                w_fin_hi = r_neg_r ? -w_next_hi : w_next_hi;
            end
        end else begin
            w_fin_lo = w_prod_s[WIDTH-1:0];
            w_fin_hi = w_prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_equal     <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_x         <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_eq        <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mc) begin
                            r_state  <= c_BUSY;
                            r_cnt    <= '0;
                            r_hi     <= '0;
                            r_lo     <= w_x_mag;
                            r_b      <= w_y_mag;
                            r_x      <= X;
                            r_is_div <= AluOp[1];
                            r_neg_q  <= w_x_neg ^ w_y_neg;
                            r_neg_r  <= w_x_neg;
                            r_div0   <= (Y == '0);
                            r_ovf    <= w_signed_op && (X == c_MIN_NEG) && (Y == '1);
                            r_eq     <= (X == Y);
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_res;
                            r_result_hi <= '0;
                            r_equal     <= (X == Y);
                        end
                    end
                end
                c_BUSY: begin
                    r_hi <= w_next_hi;
                    r_lo <= w_next_lo;
                    if (r_cnt == c_LAST) begin
                        r_state     <= c_IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_result    <= w_fin_lo;
                        r_result_hi <= w_fin_hi;
                        r_equal     <= r_eq;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Summary  : Self-checking bench for seq_alu (WIDTH=32): vector table, corner
//            sequences and randomized ops against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_seq_alu;

    localparam int c_W = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      AluOp;
    logic [c_W-1:0]  X;
    logic [c_W-1:0]  Y;
    logic            out_valid;
    logic [c_W-1:0]  Result;
    logic [c_W-1:0]  ResultHi;
    logic            Equal;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        eq;
    } vec_t;

    vec_t vecs[18];

    seq_alu #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .AluOp     (AluOp),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .Result    (Result),
        .ResultHi  (ResultHi),
        .Equal     (Equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built directly from the arithmetic definitions.
    function automatic void ref_model(input logic [4:0] op, input logic [31:0] x,
                                      input logic [31:0] y, output logic [31:0] lo,
                                      output logic [31:0] hi);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        lo = '0;
        hi = '0;
        case (op)
            5'd0:  lo = x << y[4:0];
            5'd1:  lo = sx >>> y[4:0];
            5'd2:  lo = x >> y[4:0];
            5'd5:  lo = x + y;
            5'd6:  lo = x - y;
            5'd7:  lo = x & y;
            5'd8:  lo = x | y;
            5'd9:  lo = x ^ y;
            5'd10: lo = ~(x | y);
            5'd11: lo = (sx < sy) ? 32'd1 : 32'd0;
            5'd12: lo = (x < y) ? 32'd1 : 32'd0;
            5'd16: begin
                sp = longint'(sx) * longint'(sy);
                {hi, lo} = sp;
            end
            5'd17: begin
                up = {32'd0, x} * {32'd0, y};
                {hi, lo} = up;
            end
            5'd18: begin
                if (y == 32'd0) begin
                    lo = '1; hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    lo = x; hi = '0;
                end else begin
                    lo = sx / sy; hi = sx % sy;
                end
            end
            5'd19: begin
                if (y == 32'd0) begin
                    lo = '1; hi = x;
                end else begin
                    lo = x / y; hi = x % y;
                end
            end
            default: begin
                lo = '0; hi = '0;
            end
        endcase
    endfunction

    // Issue one op, wait for its result, check latency/values and the pulse width.
    task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic eeq,
                          input string tag);
        int lat;
        int exp_lat;
        exp_lat = (op >= 5'd16 && op <= 5'd19) ? c_W : 0;
        @(negedge clk);
        check({tag, " ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        AluOp    = op;
        X        = x;
        Y        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " Result"}, 64'(Result), 64'(elo));
        check({tag, " ResultHi"}, 64'(ResultHi), 64'(ehi));
        check({tag, " Equal"}, 64'(Equal), 64'(eeq));
        @(posedge clk);
        #1;
        check({tag, " pulse"}, 64'(out_valid), 64'(0));
        check({tag, " hold"}, 64'(Result), 64'(elo));
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] elo;
        logic [31:0] ehi;
        int          lat;
        int          seen;
        int          drops;

        vecs[0]  = '{5'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b0};
        vecs[1]  = '{5'd6,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[2]  = '{5'd7,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0, 1'b0};
        vecs[3]  = '{5'd8,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0, 1'b0};
        vecs[4]  = '{5'd9,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 32'h0, 1'b0};
        vecs[5]  = '{5'd10, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 32'h0, 1'b0};
        vecs[6]  = '{5'd0,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 32'h0, 1'b0};
        vecs[7]  = '{5'd2,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 32'h0, 1'b0};
        vecs[8]  = '{5'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0};
        vecs[9]  = '{5'd12, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b0};
        vecs[10] = '{5'd16, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{5'd17, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'h0000_0002, 1'b0};
        vecs[12] = '{5'd18, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{5'd19, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0007, 1'b0};
        vecs[14] = '{5'd18, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        vecs[15] = '{5'd18, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0};
        vecs[16] = '{5'd16, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1};
        vecs[17] = '{5'd3,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 32'h0, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        AluOp    = '0;
        X        = '0;
        Y        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset Result", 64'(Result), 64'(0));
        check("reset ResultHi", 64'(ResultHi), 64'(0));
        check("reset Equal", 64'(Equal), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].lo, vecs[i].hi, vecs[i].eq,
                   $sformatf("vec%0d", i));
        end

        // ADD then SRA back-to-back, in_ready must stay high
        drops = 0;
        @(negedge clk);
        in_valid = 1'b1; AluOp = 5'd5; X = 32'hFFFF_FFFF; Y = 32'h1;
        @(posedge clk);
        #1;
        if (!in_ready) drops++;
        check("b2b add valid", 64'(out_valid), 64'(1));
        check("b2b add Result", 64'(Result), 64'(0));
        check("b2b add Equal", 64'(Equal), 64'(0));
        AluOp = 5'd1; X = 32'h8000_0000; Y = 32'h21;
        @(posedge clk);
        #1;
        if (!in_ready) drops++;
        in_valid = 1'b0;
        check("b2b sra valid", 64'(out_valid), 64'(1));
        check("b2b sra Result", 64'(Result), 64'(32'hC000_0000));
        check("b2b in_ready drops", 64'(drops), 64'(0));
        @(posedge clk);
        #1;

        // DIV overflow with an ADD held on in_valid throughout BUSY
        @(negedge clk);
        in_valid = 1'b1; AluOp = 5'd18; X = 32'h8000_0000; Y = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        AluOp = 5'd5; X = 32'd10; Y = 32'd20;
        check("busy in_ready", 64'(in_ready), 64'(0));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ovf latency", 64'(lat), 64'(c_W));
        check("ovf Result", 64'(Result), 64'(32'h8000_0000));
        check("ovf ResultHi", 64'(ResultHi), 64'(0));
        check("ovf in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("held add valid", 64'(out_valid), 64'(1));
        check("held add Result", 64'(Result), 64'(30));
        @(posedge clk);
        #1;
        check("held add pulse", 64'(out_valid), 64'(0));

        // Reset at edge N+10 of a DIVU aborts it
        @(negedge clk);
        in_valid = 1'b1; AluOp = 5'd19; X = 32'd1234567; Y = 32'd89;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort out_valid", 64'(out_valid), 64'(0));
        check("abort Result", 64'(Result), 64'(0));
        check("abort ResultHi", 64'(ResultHi), 64'(0));
        check("abort Equal", 64'(Equal), 64'(0));
        check("abort in_ready rst", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("abort in_ready rel", 64'(in_ready), 64'(1));
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort no out_valid", 64'(seen), 64'(0));
        run_op(5'd6, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, "sub after abort");

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 6) op = 5'($urandom_range(0, 31));
            else op = 5'(16 + $urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'($urandom_range(0, 15));
                2: x = y;
                3: y = 32'hFFFF_FFFF;
                4: x = 32'h8000_0000;
                default: ;
            endcase
            ref_model(op, x, y, elo, ehi);
            run_op(op, x, y, elo, ehi, (x == y), $sformatf("rand%0d op%0d", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived from WIDTH and never overridden.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 AluOp  input  5  operation code, per REQ-012.
REQ-008 X, Y  input  WIDTH each  operands; Y is the divisor and Y[SHW-1:0] is the shift amount.
REQ-009 out_valid  output  1  one-cycle pulse; Result, ResultHi and Equal are valid.
REQ-010 Result, ResultHi  output  WIDTH each  low and high result; registered.
REQ-011 Equal  output  1  registered (X == Y) of the accepted operation.

Function
REQ-012 Opcode map:
- 0 SLL; 1 SRA; 2 SRL; 5 ADD; 6 SUB; 7 AND; 8 OR; 9 XOR; 10 NOR; 11 SLT signed; 12 SLTU.
- 16 MUL signed; 17 MULU; 18 DIV signed; 19 DIVU.
- Any other code returns Result=0, ResultHi=0.
REQ-013 An operation is accepted on a rising edge where in_valid & in_ready & !rst; inputs are sampled only at that edge.
REQ-014 Single-cycle ops (all codes other than 16-19):
- result registered at the accepting edge;
- out_valid high for the following cycle;
- ResultHi = 0;
- in_ready stays high, so one operation per cycle is sustained.
REQ-015 ADD and SUB wrap modulo 2^WIDTH with no overflow flag; shifts use Y[SHW-1:0] only; SLT and SLTU return 1 or 0.
REQ-016 State machine: IDLE and BUSY.
- IDLE -> BUSY when a code 16-19 is accepted.
- BUSY -> IDLE when the iteration counter reaches WIDTH-1.
REQ-017 In BUSY, one bit is processed per clock:
- shift-add for multiply;
- restoring shift-subtract for divide;
- applied to operand magnitudes, with the sign fixed up on the final edge.
REQ-018 Multi-cycle latency:
- accepted at edge N;
- results and out_valid registered at edge N+WIDTH;
- out_valid high for exactly one cycle.
REQ-019 in_ready is low from edge N until edge N+WIDTH and high in the out_valid cycle, so a new operation may be accepted back-to-back.
REQ-020 MUL and MULU: {ResultHi, Result} = full 2*WIDTH-bit product (signed or unsigned respectively).
REQ-021 DIV and DIVU:
- Result = quotient truncated toward zero;
- ResultHi = remainder, carrying the sign of the dividend.
REQ-022 Divide by zero (Y=0): Result = all ones, ResultHi = X, for both signed and unsigned; latency unchanged.
REQ-023 Signed overflow (X = most-negative value, Y = -1): Result = X, ResultHi = 0; latency unchanged.
REQ-024 in_valid while BUSY is ignored; no queueing.
REQ-025 Result, ResultHi and Equal hold their last values when out_valid is low.

Reset
REQ-026 While rst is high at a rising edge:
- state <- IDLE; counter <- 0;
- out_valid <- 0; Result, ResultHi, Equal <- 0;
- no operation is accepted.
REQ-027 in_ready is low while rst is high and high in the first cycle after rst deasserts.
REQ-028 Reset during BUSY aborts the operation with no out_valid.

Verification
REQ-029 Bench with WIDTH=32 covers at least these scenarios:
- ADD back-to-back: X=0xFFFFFFFF, Y=1, then SRA X=0x80000000, Y=0x21 -> Result=0 with Equal=0 on cycle 1; Result=0xC0000000 on cycle 2; in_ready never drops.
- MUL X=0xFFFFFFFE (-2), Y=3 accepted at edge N -> out_valid only after edge N+32; ResultHi=0xFFFFFFFF, Result=0xFFFFFFFA; MULU on the same operands -> ResultHi=0x00000002, Result=0xFFFFFFFA.
- DIV X=-7, Y=2 -> Result=0xFFFFFFFD, ResultHi=0xFFFFFFFF; DIVU X=7, Y=0 -> Result=0xFFFFFFFF, ResultHi=7.
- DIV X=0x80000000, Y=0xFFFFFFFF -> Result=0x80000000, ResultHi=0; in_valid with ADD held during BUSY -> not accepted until the out_valid cycle, then ADD result one cycle later.
- rst asserted at edge N+10 of a DIVU -> no out_valid; all outputs 0; in_ready=1 after release; next SUB X=5, Y=5 -> Result=0, Equal=1.
- Undefined AluOp=3 -> out_valid with Result=0, ResultHi=0.
